// File: rtl/seq_mag_comparator_if.sv
// Request/response bundle for the sequential magnitude comparator.
// The master issues start/operands; the slave returns busy/done/q/nslices.
interface seq_mag_comparator_if #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
);
    localparam int NSL = WIDTH / SLICE;
    localparam int NW  = $clog2(NSL + 1);

    logic             start;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       casc_in;
    logic             busy;
    logic             done;
    logic [2:0]       q;
    logic [NW-1:0]    nslices;

    modport master (
        output start, mode, a, b, casc_in,
        input  busy, done, q, nslices
    );

    modport slave (
        input  start, mode, a, b, casc_in,
        output busy, done, q, nslices
    );
endinterface

// File: rtl/seq_mag_comparator.sv
// Multi-cycle MSB-first magnitude comparator with early exit and 74HC85-style cascade.
// Operands are mapped to unsigned keys at load so every coding compares the same way.
//
// state | meaning
// IDLE  | waiting for start; busy=0
// CMP   | comparing slice idx of the keys, idx counts down to 0
module seq_mag_comparator #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_mag_comparator_if.slave  bus
);
    localparam int NSL = WIDTH / SLICE;
    localparam int NW  = $clog2(NSL + 1);
    localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state;
    logic [WIDTH-1:0] key_a;
    logic [WIDTH-1:0] key_b;
    logic [2:0]       casc;
    logic [IW-1:0]    idx;
    logic             busy_r;
    logic             done_r;
    logic [2:0]       q_r;
    logic [NW-1:0]    nslices_r;
    logic [SLICE-1:0] sl_a;
    logic [SLICE-1:0] sl_b;

    // Sign-magnitude: negatives invert the magnitude so larger |v| gives a smaller key; -0 folds onto +0.
    function automatic logic [WIDTH-1:0] to_key(input logic [WIDTH-1:0] v, input logic [1:0] m);
        logic [WIDTH-2:0] mag;
        mag = v[WIDTH-2:0];
        case (m)
            2'b01:   to_key = {~v[WIDTH-1], v[WIDTH-2:0]};
            2'b10:   to_key = (v[WIDTH-1] && mag != '0) ? {1'b0, ~mag} : {1'b1, mag};
            default: to_key = v;
        endcase
    endfunction

    always_comb begin
        sl_a = key_a[idx*SLICE +: SLICE];
        sl_b = key_b[idx*SLICE +: SLICE];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            key_a     <= '0;
            key_b     <= '0;
            casc      <= '0;
            idx       <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            q_r       <= '0;
            nslices_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        key_a  <= to_key(bus.a, bus.mode);
                        key_b  <= to_key(bus.b, bus.mode);
                        casc   <= bus.casc_in;
                        idx    <= IW'(NSL - 1);
                        busy_r <= 1'b1;
                        state  <= CMP;
                    end
                end
                CMP: begin
                    if (sl_a != sl_b || idx == '0) begin
                        state     <= IDLE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        nslices_r <= NW'(NSL - int'(idx));
                        if (sl_a > sl_b)
                            q_r <= 3'b100;
                        else if (sl_a < sl_b)
                            q_r <= 3'b001;
                        else
                            q_r <= casc;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.q       = q_r;
    assign bus.nslices = nslices_r;
endmodule

// File: tb/tb_seq_mag_comparator.sv
// Scoreboard bench for seq_mag_comparator: random and directed requests against an
// arithmetic reference model; a separate monitor checks every done pulse.
module tb_seq_mag_comparator;
    localparam int WIDTH = 8;
    localparam int SLICE = 4;
    localparam int NSL   = WIDTH / SLICE;

    typedef struct {
        logic [2:0] q;
        int         n;
        int         acc_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    seq_mag_comparator_if #(.WIDTH(WIDTH), .SLICE(SLICE)) bif ();

    seq_mag_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic int value_of(input logic [WIDTH-1:0] v, input logic [1:0] m);
        logic [WIDTH-2:0] mag;
        mag = v[WIDTH-2:0];
        case (m)
            2'b01:   return int'($signed(v));
            2'b10:   return v[WIDTH-1] ? -int'(mag) : int'(mag);
            default: return int'(v);
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] key_of(input logic [WIDTH-1:0] v, input logic [1:0] m);
        logic [WIDTH-2:0] mag;
        mag = v[WIDTH-2:0];
        case (m)
            2'b01:   return {~v[WIDTH-1], v[WIDTH-2:0]};
            2'b10:   return (v[WIDTH-1] && mag != '0) ? {1'b0, ~mag} : {1'b1, mag};
            default: return v;
        endcase
    endfunction

    // Expected outcome: q from numeric values, slice count from the MSB-first scan of keys.
    function automatic exp_t model(input logic [1:0] m, input logic [WIDTH-1:0] va,
                                   input logic [WIDTH-1:0] vb, input logic [2:0] c);
        exp_t e;
        int x, y;
        logic [WIDTH-1:0] ka, kb;
        x  = value_of(va, m);
        y  = value_of(vb, m);
        ka = key_of(va, m);
        kb = key_of(vb, m);
        e.q = (x > y) ? 3'b100 : (x < y) ? 3'b001 : c;
        e.n = NSL;
        for (int s = 1; s <= NSL; s++) begin
            if (ka[(NSL-s)*SLICE +: SLICE] != kb[(NSL-s)*SLICE +: SLICE]) begin
                e.n = s;
                break;
            end
        end
        e.acc_cyc = 0;
        return e;
    endfunction

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bif.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("q", int'(bif.q), int'(e.q));
                check("nslices", int'(bif.nslices), e.n);
                check("latency", cyc - e.acc_cyc, e.n);
            end
        end
    end

    task automatic issue(input logic [1:0] m, input logic [WIDTH-1:0] va,
                         input logic [WIDTH-1:0] vb, input logic [2:0] c,
                         output logic done_at_issue);
        exp_t e;
        int waited;
        waited = 0;
        while (bif.busy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("busy_wait_timeout", int'(waited >= 50), 0);
        done_at_issue = bif.done;
        bif.start   = 1'b1;
        bif.mode    = m;
        bif.a       = va;
        bif.b       = vb;
        bif.casc_in = c;
        e = model(m, va, vb, c);
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        bif.start   = 1'b0;
        bif.mode    = 2'($urandom);
        bif.a       = WIDTH'($urandom);
        bif.b       = WIDTH'($urandom);
        bif.casc_in = 3'($urandom);
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while ((sb.size() != 0 || bif.busy) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("drain_timeout", int'(waited >= 100), 0);
        @(negedge clk);
    endtask

    initial begin
        logic d;
        logic [WIDTH-1:0] ra, rb;
        bif.start   = 1'b0;
        bif.mode    = 2'b00;
        bif.a       = '0;
        bif.b       = '0;
        bif.casc_in = 3'b010;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(bif.busy), 0);
        check("rst_done", int'(bif.done), 0);
        check("rst_q", int'(bif.q), 0);
        check("rst_nslices", int'(bif.nslices), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 8'hA5, 8'hA3, 3'b010, d);
        drain();
        issue(2'b00, 8'h12, 8'h92, 3'b010, d);
        drain();
        issue(2'b00, 8'h3C, 8'h3C, 3'b100, d);
        drain();
        check("hold_q", int'(bif.q), 3'b100);
        issue(2'b01, 8'h80, 8'h7F, 3'b010, d);
        drain();
        issue(2'b01, 8'hFF, 8'hFE, 3'b010, d);
        drain();
        issue(2'b10, 8'h80, 8'h00, 3'b010, d);
        drain();
        issue(2'b10, 8'h85, 8'h83, 3'b010, d);
        drain();
        issue(2'b11, 8'hF0, 8'h0F, 3'b001, d);
        drain();

        // Start while busy must be ignored; the next request lands on the done cycle.
        issue(2'b00, 8'h55, 8'h56, 3'b010, d);
        bif.start = 1'b1;
        bif.a     = 8'h00;
        bif.b     = 8'hFF;
        @(negedge clk);
        bif.start = 1'b0;
        issue(2'b01, 8'h90, 8'h91, 3'b100, d);
        check("back_to_back_on_done", int'(d), 1);
        drain();

        // Reset mid-compare abandons the request with no done pulse.
        issue(2'b00, 8'h77, 8'h77, 3'b001, d);
        check("busy_before_rst", int'(bif.busy), 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", int'(bif.busy), 0);
        check("midrst_done", int'(bif.done), 0);
        check("midrst_q", int'(bif.q), 0);
        check("midrst_nslices", int'(bif.nslices), 0);
        void'(sb.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        issue(2'b10, 8'h01, 8'h81, 3'b010, d);
        drain();

        for (int i = 0; i < 300; i++) begin
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = {ra[WIDTH-1 -: SLICE], WIDTH'($urandom) & {(WIDTH-SLICE){1'b1}}};
                default: rb = WIDTH'($urandom);
            endcase
            issue(2'($urandom), ra, rb, 3'($urandom), d);
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
